store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/mem_pkg.sv | 14 +
 rtl/sb_fifo.sv | 74 +++++++
 rtl/store_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side definitions: store buffer FSM encoding and default depth.
package mem_pkg;

    // Default number of store entries held in the store buffer.
    localparam int SB_DEPTH = 4;

    // Store buffer controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } sbState_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of buffered stores {word address, data}. The entries are
// presented in age order (index 0 = oldest) so forwarding logic can pick
// the youngest match by simple priority.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = 32,
    parameter int DW = 32,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [AW-3:0]                 pushAddr,
    input  logic [DW-1:0]                 pushData,
    input  logic                          pop,
    output logic [AW-3:0]                 headAddr,
    output logic [DW-1:0]                 headData,
    output logic [DEPTH-1:0][AW-3:0]      entryAddr,
    output logic [DEPTH-1:0][DW-1:0]      entryData,
    output logic [DEPTH-1:0]              entryValid,
    output logic                          full,
    output logic [PW:0]                   count
);

    logic [AW-3:0] addrMem [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          pushEn;
    logic          popEn;

    assign full   = (count == (PW+1)'(DEPTH));
    assign pushEn = push && !full;
    assign popEn  = pop && (count != '0);

    // Entry payload needs no reset: validity comes only from head and count.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            addrMem[tail] <= pushAddr;
            dataMem[tail] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pushEn) tail <= tail + 1'b1;
            if (popEn)  head <= head + 1'b1;
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Rotate storage into age order and mark the live entries.
    always_comb begin
        headAddr = addrMem[head];
        headData = dataMem[head];
        for (int i = 0; i < DEPTH; i++) begin
            entryAddr[i]  = addrMem[head + PW'(i)];
            entryData[i]  = dataMem[head + PW'(i)];
            entryValid[i] = ((PW+1)'(i) < count);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// M-stage store buffer: queues stores, forwards buffered data to loads,
// drains stores to memory when idle, and gives load misses priority.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memwriteM,
    input  logic          memreadM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    output logic [DW-1:0] readdataM,
    output logic          stallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);

    sbState_t                  state;
    sbState_t                  nextState;
    logic                      push;
    logic                      pop;
    logic [AW-3:0]             headAddr;
    logic [DW-1:0]             headData;
    logic [DEPTH-1:0][AW-3:0]  entryAddr;
    logic [DEPTH-1:0][DW-1:0]  entryData;
    logic [DEPTH-1:0]          entryValid;
    logic                      full;
    logic [PW:0]               fifoCount;
    logic [AW-3:0]             wordAddr;
    logic                      loadReq;
    logic                      hit;
    logic [DW-1:0]             hitData;
    logic                      loadMiss;
    logic                      unusedLowBits;

    assign wordAddr      = aluoutM[AW-1:2];
    assign unusedLowBits = ^aluoutM[1:0];

    // A simultaneous store and load is illegal; the store wins.
    assign loadReq  = memreadM && !memwriteM;
    assign loadMiss = loadReq && !hit;

    sb_fifo #(
        .DEPTH(DEPTH),
        .AW(AW),
        .DW(DW)
    ) fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pushAddr(wordAddr),
        .pushData(writedataM),
        .pop(pop),
        .headAddr(headAddr),
        .headData(headData),
        .entryAddr(entryAddr),
        .entryData(entryData),
        .entryValid(entryValid),
        .full(full),
        .count(fifoCount)
    );

    // Forwarding: scan oldest to youngest so the youngest match wins; the
    // entry being drained stays visible until it is actually popped.
    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entryAddr[i] == wordAddr)) begin
                hit     = 1'b1;
                hitData = entryData[i];
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state, memory handshake, stall and load-data selection. A full
    // buffer stays full for the incoming store even while popping.
    always_comb begin
        nextState = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pop       = 1'b0;
        push      = memwriteM && !full;
        stallM    = memwriteM && full;
        readdataM = (loadReq && hit) ? hitData : '0;

        case (state)
            IDLE: begin
                if (loadMiss) begin
                    stallM    = 1'b1;
                    nextState = LOAD;
                end else if (fifoCount != '0) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {headAddr, 2'b00};
                mem_wdata = headData;
                if (loadMiss) stallM = 1'b1;
                if (mem_ready) begin
                    pop       = 1'b1;
                    nextState = IDLE;
                end
            end
            LOAD: begin
                mem_req   = 1'b1;
                mem_addr  = {wordAddr, 2'b00};
                readdataM = '0;
                if (mem_ready) begin
                    readdataM = mem_rdata;
                    nextState = IDLE;
                end else begin
                    stallM = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase

        if (!rst) begin
            push      = 1'b0;
            pop       = 1'b0;
            stallM    = 1'b0;
            readdataM = '0;
        end
    end

endmodule
